// File: rtl/numberpad_pkg.sv
// Shared types and constants for the three-digit BCD score counter.
package numberpad_pkg;

    localparam int DIGIT_W       = 4;
    localparam int SCORE_MAX_BCD = 999;

    typedef logic signed [2:0]  delta_t;
    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef struct packed {
        bcd_t hun;
        bcd_t ten;
        bcd_t one;
    } score_t;

    // Elaboration-time conversion of a binary constant into three BCD digits.
    function automatic score_t to_bcd(input int value);
        score_t s;
        s.hun = bcd_t'((value / 100) % 10);
        s.ten = bcd_t'((value / 10) % 10);
        s.one = bcd_t'(value % 10);
        return s;
    endfunction

endpackage

// File: rtl/numberpad_button_conditioner.sv
// Button path: 2-flop synchronizer, optional debounce, arm mask and rising-edge pulse.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pulse_out
);

    // The arm window also covers the debounce fill so a button held across
    // reset release never looks like a fresh press.
    localparam int ARM_CYCLES = 2 + DEBOUNCE_CYCLES;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);
    localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(ARM_CYCLES);

    logic [1:0]       sync;
    logic             level;
    logic             prev;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], btn_in};
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign level = sync[1];
        end else begin : g_debounce
            localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt;
            logic             level_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt     <= CNT_LOAD;
                    level_q <= 1'b0;
                end else if (sync[1] == level_q) begin
                    cnt <= CNT_LOAD;
                end else if (cnt == '0) begin
                    level_q <= sync[1];
                    cnt     <= CNT_LOAD;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end

            assign level = level_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt <= ARM_LOAD;
        end else if (arm_cnt != '0) begin
            arm_cnt <= arm_cnt - 1'b1;
        end
    end

    assign armed = (arm_cnt == '0);

    // While unarmed the previous level is forced high, masking any edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b1;
        end else if (!armed) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign pulse_out = armed & level & ~prev;

endmodule

// File: rtl/numberpad.sv
// Three-digit BCD score counter driven by four debounced push-buttons, saturating at 0 and MAX_SCORE.
module numberpad
    import numberpad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int MAX_SCORE       = SCORE_MAX_BCD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a1,
    input  logic               a2,
    input  logic               d1,
    input  logic               d2,
    output logic [DIGIT_W-1:0] num1,
    output logic [DIGIT_W-1:0] num2,
    output logic [DIGIT_W-1:0] num3
);

    localparam score_t            MAX_BCD = to_bcd(MAX_SCORE);
    localparam logic signed [11:0] MAX_S  = 12'(MAX_SCORE);

    logic [3:0]         btn;
    logic [3:0]         ev;
    delta_t             delta;
    logic [1:0]         mag;
    score_t             score_q;
    score_t             stepped;
    score_t             nxt;
    logic [9:0]         score_bin;
    logic signed [11:0] sum;
    logic [4:0]         one_t;
    logic [4:0]         ten_t;
    logic               carry1;
    logic               carry2;

    assign btn = {d2, d1, a2, a1};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_in   (btn[i]),
            .pulse_out(ev[i])
        );
    end

    always_comb begin
        delta = '0;
        if (ev[0]) delta = delta + 3'sd1;
        if (ev[1]) delta = delta + 3'sd2;
        if (ev[2]) delta = delta - 3'sd1;
        if (ev[3]) delta = delta - 3'sd2;
    end

    assign mag = delta[2] ? (~delta[1:0] + 2'd1) : delta[1:0];

    // Binary view of the score is used only to decide saturation.
    always_comb begin
        score_bin = 10'(score_q.hun) * 10'd100 + 10'(score_q.ten) * 10'd10 + 10'(score_q.one);
        sum       = $signed({2'b00, score_bin}) + $signed({{9{delta[2]}}, delta});
    end

    always_comb begin
        stepped = score_q;
        one_t   = '0;
        ten_t   = '0;
        carry1  = 1'b0;
        carry2  = 1'b0;
        if (!delta[2]) begin
            one_t = {1'b0, score_q.one} + {3'b000, mag};
            if (one_t > 5'd9) begin
                one_t  = one_t - 5'd10;
                carry1 = 1'b1;
            end
            ten_t = {1'b0, score_q.ten} + {4'b0000, carry1};
            if (ten_t > 5'd9) begin
                ten_t  = ten_t - 5'd10;
                carry2 = 1'b1;
            end
            stepped.one = one_t[3:0];
            stepped.ten = ten_t[3:0];
            stepped.hun = score_q.hun + {3'b000, carry2};
        end else begin
            if (score_q.one < {2'b00, mag}) begin
                stepped.one = score_q.one + 4'd10 - {2'b00, mag};
                carry1      = 1'b1;
            end else begin
                stepped.one = score_q.one - {2'b00, mag};
            end
            if (carry1) begin
                if (score_q.ten == 4'd0) begin
                    stepped.ten = 4'd9;
                    carry2      = 1'b1;
                end else begin
                    stepped.ten = score_q.ten - 4'd1;
                end
            end
            stepped.hun = score_q.hun - {3'b000, carry2};
        end
    end

    always_comb begin
        if (sum[11]) begin
            nxt = '0;
        end else if (sum > MAX_S) begin
            nxt = MAX_BCD;
        end else begin
            nxt = stepped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
        end else begin
            score_q <= nxt;
        end
    end

    assign num1 = score_q.hun;
    assign num2 = score_q.ten;
    assign num3 = score_q.one;

endmodule

// File: tb/tb_numberpad.sv
// Self-checking bench for numberpad: table of button presses plus scoreboarded corner sequences.
module tb_numberpad;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a1, a2, d1, d2;
    logic       b1;
    logic [3:0] num1, num2, num3;
    logic [3:0] dn1, dn2, dn3;

    always #5 clk = ~clk;

    numberpad #(.DEBOUNCE_CYCLES(0), .MAX_SCORE(999)) dut (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .d1(d1), .d2(d2),
        .num1(num1), .num2(num2), .num3(num3)
    );

    numberpad #(.DEBOUNCE_CYCLES(4), .MAX_SCORE(999)) dut_db (
        .clk(clk), .rst_n(rst_n), .a1(b1), .a2(1'b0), .d1(1'b0), .d2(1'b0),
        .num1(dn1), .num2(dn2), .num3(dn3)
    );

    typedef struct {
        logic [3:0] btn;   // {d2,d1,a2,a1}
        int         hold;
        int         exp;
        string      name;
    } vec_t;

    vec_t tbl[17];
    int   vectors     = 0;
    int   miscompares = 0;
    int   model       = 0;
    int   exp_q[$];

    task automatic check(input string name, input int exp,
                         input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        vectors++;
        if (h !== 4'(exp / 100) || t !== 4'((exp / 10) % 10) || o !== 4'(exp % 10)) begin
            miscompares++;
            $display("FAIL %s: got %0d%0d%0d expected %03d", name, h, t, o, exp);
        end
    endtask

    function automatic int step(input int cur, input logic [3:0] btn);
        int v;
        v = cur + (btn[0] ? 1 : 0) + (btn[1] ? 2 : 0) - (btn[2] ? 1 : 0) - (btn[3] ? 2 : 0);
        if (v < 0)   v = 0;
        if (v > 999) v = 999;
        return v;
    endfunction

    task automatic press(input logic [3:0] btn, input int hold, input int exp, input string name);
        exp_q.push_back(exp);
        @(negedge clk);
        {d2, d1, a2, a1} = btn;
        repeat (hold) @(negedge clk);
        {d2, d1, a2, a1} = 4'b0000;
        repeat (6) @(negedge clk);
        check(name, exp_q.pop_front(), num1, num2, num3);
    endtask

    task automatic ramp_to(input int target);
        logic [3:0] b;
        while (model < target) begin
            b     = (target - model >= 3) ? 4'b0011 : 4'b0001;
            model = step(model, b);
            press(b, 2, model, "ramp");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b0001,  3,  1, "a1"};
        tbl[1]  = '{4'b0010,  3,  3, "a2"};
        tbl[2]  = '{4'b0100,  3,  2, "d1"};
        tbl[3]  = '{4'b1000,  3,  0, "d2"};
        tbl[4]  = '{4'b1000,  3,  0, "d2_at_zero"};
        tbl[5]  = '{4'b0100,  3,  0, "d1_at_zero"};
        tbl[6]  = '{4'b0001, 50,  1, "a1_held"};
        tbl[7]  = '{4'b0000,  5,  1, "idle_after_release"};
        tbl[8]  = '{4'b0010,  3,  3, "a2_to_3"};
        tbl[9]  = '{4'b0010,  3,  5, "a2_to_5"};
        tbl[10] = '{4'b0011,  3,  8, "a1_a2_simul"};
        tbl[11] = '{4'b1100,  3,  5, "d1_d2_simul"};
        tbl[12] = '{4'b0110,  3,  6, "a2_d1_simul"};
        tbl[13] = '{4'b0001,  3,  7, "a1_to_7"};
        tbl[14] = '{4'b0001,  3,  8, "a1_to_8"};
        tbl[15] = '{4'b0001,  3,  9, "a1_to_9"};
        tbl[16] = '{4'b0001,  3, 10, "carry_009"};

        rst_n = 1'b0;
        {d2, d1, a2, a1} = 4'b0000;
        b1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("reset_idle", 0, num1, num2, num3);
        check("reset_idle_db", 0, dn1, dn2, dn3);

        for (int i = 0; i < 17; i++) begin
            press(tbl[i].btn, tbl[i].hold, tbl[i].exp, tbl[i].name);
            model = tbl[i].exp;
        end

        ramp_to(99);
        press(4'b0010, 3, 101, "carry_099_a2");
        press(4'b0100, 3, 100, "borrow_101");
        press(4'b0100, 3,  99, "borrow_100");
        model = 99;

        ramp_to(998);
        press(4'b0010, 3, 999, "sat_998_a2");
        press(4'b0001, 3, 999, "sat_999_a1");
        press(4'b1000, 3, 997, "d2_from_999");

        // Reset mid-operation with a1 held across release.
        @(negedge clk);
        a1    = 1'b1;
        rst_n = 1'b0;
        #1;
        check("reset_async", 0, num1, num2, num3);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        a1 = 1'b0;
        repeat (6) @(negedge clk);
        exp_q.push_back(0);
        check("held_through_reset", exp_q.pop_front(), num1, num2, num3);
        press(4'b0001, 3, 1, "after_rearm");

        // Debounced instance: short glitch rejected, long press accepted once.
        @(negedge clk);
        exp_q.push_back(0);
        b1 = 1'b1;
        repeat (2) @(negedge clk);
        b1 = 1'b0;
        repeat (15) @(negedge clk);
        check("db_glitch", exp_q.pop_front(), dn1, dn2, dn3);

        exp_q.push_back(1);
        b1 = 1'b1;
        repeat (6) @(negedge clk);
        b1 = 1'b0;
        repeat (15) @(negedge clk);
        check("db_press", exp_q.pop_front(), dn1, dn2, dn3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
